// File: rtl/matmul_tile_mem_ctrl.sv
// matmul_tile_mem_ctrl: A/B/C bank memory subsystem for an NUM_BANKS x NUM_BANKS
// tiled systolic matmul. Host loads A/B, array reads A/B and writes C, host drains C.
//
// Ports
//   clk_mem, reset           clock, synchronous active-high reset
//   host_wr_*                host A/B load port (valid/ready), 2-cycle write path
//   start_in/start_mat_mul   compute start pulse / level to array for all of COMPUTE
//   done_mat_mul             array finished, back to IDLE
//   a_addr/a_data, b_addr/b_data  array read ports, 3-cycle latency per bank
//   c_data/c_valid           array results, one word per bank, written together
//   rd_req/rd_base/rd_len    drain request: rd_len words per bank from rd_base
//   rd_data/rd_valid/rd_ready/rd_last  drain stream, bank 0 first
//   rd_busy                  high while draining
//   cycle_count              COMPUTE cycle counter, only with MATMUL_MEM_IF_PERF_CNT_EN
//
// Optional feature macro: MATMUL_MEM_IF_PERF_CNT_EN
module matmul_tile_mem_ctrl #(
    parameter  int DWIDTH       = 8,
    parameter  int MAT_MUL_SIZE = 8,
    parameter  int AWIDTH       = 7,
    parameter  int NUM_BANKS    = 2,
    localparam int W            = MAT_MUL_SIZE * DWIDTH,
    localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                        clk_mem,
    input  logic                        reset,
    input  logic                        host_wr_valid,
    output logic                        host_wr_ready,
    input  logic                        host_wr_mat,
    input  logic [BANK_W-1:0]           host_wr_bank,
    input  logic [AWIDTH-1:0]           host_wr_addr,
    input  logic [W-1:0]                host_wr_data,
    input  logic                        start_in,
    output logic                        start_mat_mul,
    input  logic                        done_mat_mul,
    input  logic [NUM_BANKS*AWIDTH-1:0] a_addr,
    output logic [NUM_BANKS*W-1:0]      a_data,
    input  logic [NUM_BANKS*AWIDTH-1:0] b_addr,
    output logic [NUM_BANKS*W-1:0]      b_data,
    input  logic [NUM_BANKS*W-1:0]      c_data,
    input  logic                        c_valid,
    input  logic                        rd_req,
    input  logic [AWIDTH-1:0]           rd_base,
    input  logic [AWIDTH:0]             rd_len,
    output logic [W-1:0]                rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic                        rd_last,
    output logic                        rd_busy
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
    ,
    output logic [31:0]                 cycle_count
`endif
);

    localparam int MEM_SIZE = 2 ** AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN
    } state_e;

    state_e              state_q;
    logic                start_q;
    logic                busy_q;
    logic [AWIDTH-1:0]   c_wr_addr_q;
    logic                wr_pend_q;
    logic [W-1:0]        wdata_q;

    logic [AWIDTH-1:0]   base_q;
    logic [AWIDTH:0]     len_q;
    logic [AWIDTH:0]     iss_off_q;
    logic [BANK_W-1:0]   iss_bank_q;
    logic                iss_done_q;
    logic [1:0]          credit_q;

    logic                pipe_vld_q;
    logic [BANK_W-1:0]   pipe_bank_q;
    logic                pipe_last_q;

    logic [1:0][W-1:0]   fifo_data_q;
    logic [1:0]          fifo_last_q;
    logic                wptr_q;
    logic                rptr_q;
    logic [1:0]          cnt_q;

`ifdef MATMUL_MEM_IF_PERF_CNT_EN
    logic [31:0]         cycle_q;
    assign cycle_count = cycle_q;
`endif

    logic                    wr_accept;
    logic                    issue;
    logic                    iss_last;
    logic                    pop;
    logic                    c_we;
    logic [AWIDTH-1:0]       rd_addr;
    logic [NUM_BANKS-1:0][W-1:0] c_rq;

    assign host_wr_ready = (state_q == S_IDLE) && !reset;
    assign wr_accept     = host_wr_valid && host_wr_ready;
    assign c_we          = (state_q == S_COMPUTE) && c_valid;

    // A C read issues only while a skid slot is free (credit held).
    assign issue    = (state_q == S_DRAIN) && !iss_done_q && (credit_q != 2'd0);
    assign iss_last = (iss_bank_q == BANK_W'(NUM_BANKS - 1))
                   && (iss_off_q == len_q - 1'b1);
    assign rd_addr  = base_q + iss_off_q[AWIDTH-1:0];

    assign rd_valid      = (cnt_q != 2'd0);
    assign rd_data       = fifo_data_q[rptr_q];
    assign rd_last       = rd_valid && fifo_last_q[rptr_q];
    assign pop           = rd_valid && rd_ready;
    assign rd_busy       = busy_q;
    assign start_mat_mul = start_q;

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            c_wr_addr_q <= '0;
            wr_pend_q   <= 1'b0;
            wdata_q     <= '0;
            base_q      <= '0;
            len_q       <= '0;
            iss_off_q   <= '0;
            iss_bank_q  <= '0;
            iss_done_q  <= 1'b0;
            credit_q    <= 2'd2;
            pipe_vld_q  <= 1'b0;
            pipe_bank_q <= '0;
            pipe_last_q <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            cnt_q       <= 2'd0;
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
            cycle_q     <= '0;
`endif
        end else begin
            wr_pend_q <= wr_accept;
            if (wr_accept) begin
                wdata_q <= host_wr_data;
            end

            // One-cycle C read pipe feeding the skid buffer.
            pipe_vld_q  <= issue;
            pipe_bank_q <= iss_bank_q;
            pipe_last_q <= iss_last;

            if (pipe_vld_q) begin
                fifo_data_q[wptr_q] <= c_rq[pipe_bank_q];
                fifo_last_q[wptr_q] <= pipe_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q    <= cnt_q + {1'b0, pipe_vld_q} - {1'b0, pop};
            credit_q <= credit_q - {1'b0, issue} + {1'b0, pop};

            if (issue) begin
                if (iss_off_q == len_q - 1'b1) begin
                    iss_off_q <= '0;
                    if (iss_bank_q == BANK_W'(NUM_BANKS - 1)) begin
                        iss_done_q <= 1'b1;
                    end else begin
                        iss_bank_q <= iss_bank_q + 1'b1;
                    end
                end else begin
                    iss_off_q <= iss_off_q + 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start_in && !host_wr_valid && !wr_pend_q) begin
                        state_q <= S_COMPUTE;
                        start_q <= 1'b1;
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
                        cycle_q <= '0;
`endif
                    end else if (rd_req && (rd_len != '0)) begin
                        state_q    <= S_DRAIN;
                        busy_q     <= 1'b1;
                        base_q     <= rd_base;
                        len_q      <= rd_len;
                        iss_off_q  <= '0;
                        iss_bank_q <= '0;
                        iss_done_q <= 1'b0;
                        credit_q   <= 2'd2;
                    end
                end
                S_COMPUTE: begin
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
                    if (cycle_q != 32'hFFFF_FFFF) begin
                        cycle_q <= cycle_q + 32'd1;
                    end
`endif
                    if (c_valid) begin
                        c_wr_addr_q <= c_wr_addr_q + 1'b1;
                    end
                    // A c_valid in the done cycle still writes at the old address.
                    if (done_mat_mul) begin
                        state_q     <= S_IDLE;
                        start_q     <= 1'b0;
                        c_wr_addr_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (pop && fifo_last_q[rptr_q]) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic [W-1:0]      a_mem [MEM_SIZE];
        logic [W-1:0]      b_mem [MEM_SIZE];
        logic [W-1:0]      c_mem [MEM_SIZE];
        logic [AWIDTH-1:0] a_ad_q;
        logic [AWIDTH-1:0] b_ad_q;
        logic              a_we_q;
        logic              b_we_q;
        logic [W-1:0]      a_rd_q;
        logic [W-1:0]      b_rd_q;
        logic [W-1:0]      a_dq;
        logic [W-1:0]      b_dq;
        logic [W-1:0]      c_rd_q;
        logic              a_hit;
        logic              b_hit;

        assign a_hit = wr_accept && !host_wr_mat
                    && (host_wr_bank == BANK_W'(i));
        assign b_hit = wr_accept && host_wr_mat
                    && (host_wr_bank == BANK_W'(i));

        // Address register: a pending host write steals the port.
        always_ff @(posedge clk_mem) begin
            if (reset) begin
                a_we_q <= 1'b0;
                b_we_q <= 1'b0;
                a_ad_q <= '0;
                b_ad_q <= '0;
                a_dq   <= '0;
                b_dq   <= '0;
            end else begin
                a_we_q <= a_hit;
                b_we_q <= b_hit;
                a_ad_q <= a_hit ? host_wr_addr : a_addr[i*AWIDTH +: AWIDTH];
                b_ad_q <= b_hit ? host_wr_addr : b_addr[i*AWIDTH +: AWIDTH];
                a_dq   <= a_rd_q;
                b_dq   <= b_rd_q;
            end
        end

        always_ff @(posedge clk_mem) begin
            if (a_we_q) begin
                a_mem[a_ad_q] <= wdata_q;
            end
            if (b_we_q) begin
                b_mem[b_ad_q] <= wdata_q;
            end
            a_rd_q <= a_mem[a_ad_q];
            b_rd_q <= b_mem[b_ad_q];
        end

        always_ff @(posedge clk_mem) begin
            if (c_we) begin
                c_mem[c_wr_addr_q] <= c_data[i*W +: W];
            end
            if (issue) begin
                c_rd_q <= c_mem[rd_addr];
            end
        end

        assign c_rq[i]          = c_rd_q;
        assign a_data[i*W +: W] = a_dq;
        assign b_data[i*W +: W] = b_dq;
    end

endmodule

// File: tb/tb_matmul_tile_mem_ctrl.sv
// Self-checking bench for matmul_tile_mem_ctrl: table vectors plus
// randomized drains scored against array models of the A/B/C banks.
module tb_matmul_tile_mem_ctrl;

    localparam int AW  = 7;
    localparam int NB  = 2;
    localparam int W   = 64;
    localparam int MEM = 128;

    logic              clk_mem = 1'b0;
    logic              reset = 1'b1;
    logic              host_wr_valid = 1'b0;
    logic              host_wr_ready;
    logic              host_wr_mat = 1'b0;
    logic [0:0]        host_wr_bank = '0;
    logic [AW-1:0]     host_wr_addr = '0;
    logic [W-1:0]      host_wr_data = '0;
    logic              start_in = 1'b0;
    logic              start_mat_mul;
    logic              done_mat_mul = 1'b0;
    logic [NB*AW-1:0]  a_addr = '0;
    logic [NB*W-1:0]   a_data;
    logic [NB*AW-1:0]  b_addr = '0;
    logic [NB*W-1:0]   b_data;
    logic [NB*W-1:0]   c_data = '0;
    logic              c_valid = 1'b0;
    logic              rd_req = 1'b0;
    logic [AW-1:0]     rd_base = '0;
    logic [AW:0]       rd_len = '0;
    logic [W-1:0]      rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic              rd_last;
    logic              rd_busy;
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
    logic [31:0]       cycle_count;
`endif

    always #5 clk_mem = ~clk_mem;

    matmul_tile_mem_ctrl dut (
        .clk_mem      (clk_mem),
        .reset        (reset),
        .host_wr_valid(host_wr_valid),
        .host_wr_ready(host_wr_ready),
        .host_wr_mat  (host_wr_mat),
        .host_wr_bank (host_wr_bank),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .start_in     (start_in),
        .start_mat_mul(start_mat_mul),
        .done_mat_mul (done_mat_mul),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .c_data       (c_data),
        .c_valid      (c_valid),
        .rd_req       (rd_req),
        .rd_base      (rd_base),
        .rd_len       (rd_len),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .rd_busy      (rd_busy)
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;

    // Reference contents of every bank; cw is the next C write slot.
    logic [W-1:0] ma [NB][MEM];
    logic [W-1:0] mb [NB][MEM];
    logic [W-1:0] mc [NB][MEM];
    int cw = 0;

    typedef struct {
        bit           mat;
        int           bank;
        int           addr;
        logic [W-1:0] data;
    } wvec_t;

    typedef struct {
        int base;
        int len;
        int mode;
        bit poke;
        int exp_beats;
    } dvec_t;

    wvec_t wv [8];
    dvec_t dv [7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic host_write(input bit mat, input int bank, input int addr,
                              input logic [W-1:0] data);
        host_wr_valid = 1'b1;
        host_wr_mat   = mat;
        host_wr_bank  = bank[0];
        host_wr_addr  = AW'(addr);
        host_wr_data  = data;
        check("wr_ready_idle", host_wr_ready, 1);
        if (mat) mb[bank][addr] = data;
        else     ma[bank][addr] = data;
        @(negedge clk_mem);
        host_wr_valid = 1'b0;
    endtask

    task automatic start_compute(input bit exp_start);
        start_in = 1'b1;
        @(negedge clk_mem);
        start_in = 1'b0;
        check("start_mat_mul", start_mat_mul, exp_start);
        if (exp_start) cw = 0;
    endtask

    task automatic run_compute(input int nbeats, input bit rnd);
        int k;
        int iters;
        bit v;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        k = 0;
        iters = 0;
        while (k < nbeats) begin
            v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (k == nbeats - 1) v = 1'b1;
            c_valid      = v;
            done_mat_mul = v && (k == nbeats - 1);
            if (v) begin
                d0 = rnd ? {$urandom, $urandom} : 64'(k);
                d1 = rnd ? {$urandom, $urandom} : 64'(256 + k);
                c_data = {d1, d0};
                mc[0][cw] = d0;
                mc[1][cw] = d1;
                cw = (cw + 1) % MEM;
                k++;
            end
            iters++;
            @(negedge clk_mem);
        end
        c_valid      = 1'b0;
        done_mat_mul = 1'b0;
        check("start_low_after_done", start_mat_mul, 0);
`ifdef MATMUL_MEM_IF_PERF_CNT_EN
        check("cycle_count", cycle_count, 64'(iters));
`endif
    endtask

    task automatic stream_reads();
        for (int k = 0; k < 8 + 3; k++) begin
            if (k < 8) begin
                if (wv[k].mat) b_addr[wv[k].bank*AW +: AW] = AW'(wv[k].addr);
                else           a_addr[wv[k].bank*AW +: AW] = AW'(wv[k].addr);
            end
            if (k >= 3) begin
                if (wv[k-3].mat)
                    check("b_read", b_data[wv[k-3].bank*W +: W],
                          mb[wv[k-3].bank][wv[k-3].addr]);
                else
                    check("a_read", a_data[wv[k-3].bank*W +: W],
                          ma[wv[k-3].bank][wv[k-3].addr]);
            end
            @(negedge clk_mem);
        end
    endtask

    task automatic do_drain(input int base, input int len, input int mode,
                            input bit poke, input int exp_beats,
                            input int rst_at);
        logic [W-1:0] q[$];
        logic [W-1:0] d;
        logic [W-1:0] pd;
        logic [W-1:0] ex;
        logic v;
        logic l;
        logic pl;
        bit rdy;
        bit stalled;
        bit fin;
        int got;
        int cyc;
        for (int b = 0; b < NB; b++)
            for (int o = 0; o < len; o++)
                q.push_back(mc[b][(base + o) % MEM]);
        rd_req   = 1'b1;
        rd_base  = AW'(base);
        rd_len   = (AW+1)'(len);
        rd_ready = 1'b0;
        @(negedge clk_mem);
        rd_req = 1'b0;
        if (len == 0) begin
            check("len0_ignored", rd_busy, 0);
            return;
        end
        check("drain_busy", rd_busy, 1);
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        fin = 1'b0;
        pd = '0;
        pl = 1'b0;
        while (!fin && cyc < 4000) begin
            if (rst_at != 0 && got == rst_at) begin
                reset    = 1'b1;
                rd_ready = 1'b0;
                @(negedge clk_mem);
                check("rst_rd_valid", rd_valid, 0);
                check("rst_rd_busy", rd_busy, 0);
                check("rst_wr_ready", host_wr_ready, 0);
                reset = 1'b0;
                @(negedge clk_mem);
                check("rst_idle_ready", host_wr_ready, 1);
                return;
            end
            v = rd_valid;
            d = rd_data;
            l = rd_last;
            if (stalled) begin
                check("stall_valid", v, 1);
                check("stall_data", d, pd);
                check("stall_last", l, pl);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            start_in = poke && (cyc == 3);
            if (poke && cyc == 4) check("start_ignored", start_mat_mul, 0);
            if (v && rdy) begin
                ex = q.pop_front();
                check("drain_data", d, ex);
                check("drain_last", l, q.size() == 0);
                got++;
                if (q.size() == 0) fin = 1'b1;
            end
            stalled  = v && !rdy;
            pd       = d;
            pl       = l;
            rd_ready = rdy;
            cyc++;
            @(negedge clk_mem);
        end
        rd_ready = 1'b0;
        start_in = 1'b0;
        check("drain_finished", fin, 1);
        check("drain_beats", got, exp_beats);
        check("drain_idle_busy", rd_busy, 0);
        check("drain_idle_valid", rd_valid, 0);
        check("drain_idle_ready", host_wr_ready, 1);
    endtask

    initial begin
        int rb;
        int rl;

        wv[0] = '{0, 0, 5,   64'h0102030405060708};
        wv[1] = '{0, 0, 6,   64'hA5A5_0000_FFFF_1234};
        wv[2] = '{0, 0, 7,   64'h0000_0000_0000_0001};
        wv[3] = '{1, 1, 0,   64'hDEAD_BEEF_CAFE_F00D};
        wv[4] = '{0, 1, 127, 64'hFFFF_FFFF_FFFF_FFFF};
        wv[5] = '{1, 0, 64,  64'h8000_0000_0000_0000};
        wv[6] = '{1, 1, 1,   {$urandom, $urandom}};
        wv[7] = '{0, 1, 33,  {$urandom, $urandom}};

        dv[0] = '{0,   4,   0, 0, 8};
        dv[1] = '{0,   4,   1, 1, 8};
        dv[2] = '{0,   0,   0, 0, 0};
        dv[3] = '{126, 4,   2, 0, 8};
        dv[4] = '{10,  1,   2, 0, 2};
        dv[5] = '{120, 16,  2, 0, 32};
        dv[6] = '{5,   128, 2, 0, 256};

        repeat (3) @(negedge clk_mem);
        check("rst_host_wr_ready", host_wr_ready, 0);
        check("rst_start", start_mat_mul, 0);
        check("rst_a_data", 64'(|a_data), 0);
        check("rst_b_data", 64'(|b_data), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_rd_busy", rd_busy, 0);
        reset = 1'b0;
        @(negedge clk_mem);
        check("idle_wr_ready", host_wr_ready, 1);

        for (int i = 0; i < 8; i++)
            host_write(wv[i].mat, wv[i].bank, wv[i].addr, wv[i].data);

        // Write stage still busy: start must be dropped.
        start_compute(0);
        start_compute(1);

        // Host write locked out during COMPUTE.
        host_wr_valid = 1'b1;
        host_wr_mat   = 1'b0;
        host_wr_bank  = 1'b0;
        host_wr_addr  = AW'(5);
        host_wr_data  = 64'h1111_2222_3333_4444;
        check("compute_wr_ready", host_wr_ready, 0);
        @(negedge clk_mem);
        check("compute_wr_ready2", host_wr_ready, 0);
        host_wr_valid = 1'b0;

        stream_reads();
        run_compute(1, 0);

        // C round trip: bank0 = k, bank1 = 0x100+k.
        start_compute(1);
        run_compute(4, 0);
        do_drain(dv[0].base, dv[0].len, dv[0].mode, dv[0].poke, dv[0].exp_beats, 0);
        do_drain(dv[1].base, dv[1].len, dv[1].mode, dv[1].poke, dv[1].exp_beats, 0);
        do_drain(dv[2].base, dv[2].len, dv[2].mode, dv[2].poke, dv[2].exp_beats, 0);

        do_drain(0, 4, 0, 0, 8, 3);
        do_drain(0, 4, 2, 0, 8, 0);

        // Fills every C address, then wraps over 0 and 1.
        start_compute(1);
        run_compute(130, 1);
        for (int i = 3; i < 7; i++)
            do_drain(dv[i].base, dv[i].len, dv[i].mode, dv[i].poke,
                     dv[i].exp_beats, 0);

        for (int i = 0; i < 4; i++) begin
            rb = $urandom_range(0, MEM - 1);
            rl = $urandom_range(1, 20);
            do_drain(rb, rl, 2, 0, NB * rl, 0);
        end

        start_compute(1);
        run_compute(20, 0);
        do_drain(0, 20, 1, 0, NB * 20, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
